// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_pkg
//  Description : Shared types and PID constants for the USB transmit arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package usb_tx_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HSK    = 3'd1,
        ST_TOK    = 3'd2,
        ST_DSTART = 3'd3,
        ST_DATA   = 3'd4,
        ST_GAP    = 3'd5
    } tx_state_t;

    // Handshake PID types
    localparam logic [1:0] HSK_ACK = 2'b00;
    localparam logic [1:0] HSK_NAK = 2'b10;

    // Token PID types
    localparam logic [1:0] TOK_OUT = 2'b00;
    localparam logic [1:0] TOK_IN  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/usb_tx_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. The search starts at
//                i_ptr and wraps; the first requester found wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Walk the requesters starting at the pointer, keep the first hit
    always_comb begin
        int k;
        k       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(i_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!o_valid && i_req[k[IW-1:0]]) begin
                o_valid            = 1'b1;
                o_gnt[k[IW-1:0]]   = 1'b1;
                o_idx              = k[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_arbiter
//  Description : Shares one encode_packet between a handshake source, a token
//                source and NUM_EP data endpoints. One packet at a time, held
//                until the tx stream's last byte, followed by a fixed gap.
//  Revision    : 1.0  initial release
// ============================================================================
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int GAP    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // handshake requester
    input  logic                  hsk_req_i,
    input  logic [1:0]            hsk_type_i,
    output logic                  hsk_ack_o,
    // token requester
    input  logic                  tok_req_i,
    input  logic [1:0]            tok_type_i,
    input  logic [15:0]           tok_data_i,
    output logic                  tok_ack_o,
    // data endpoints
    input  logic [NUM_EP-1:0]     ep_req_i,
    input  logic [2*NUM_EP-1:0]   ep_type_i,
    input  logic [NUM_EP-1:0]     ep_tvalid_i,
    output logic [NUM_EP-1:0]     ep_tready_o,
    input  logic [NUM_EP-1:0]     ep_tlast_i,
    input  logic [8*NUM_EP-1:0]   ep_tdata_i,
    output logic [NUM_EP-1:0]     ep_done_o,
    // encode_packet handshake interface
    output logic                  enc_hsk_send_o,
    output logic [1:0]            enc_hsk_type_o,
    input  logic                  enc_hsk_done_i,
    // encode_packet token interface
    output logic                  enc_tok_send_o,
    output logic [1:0]            enc_tok_type_o,
    output logic [15:0]           enc_tok_data_o,
    input  logic                  enc_tok_done_i,
    // encode_packet transaction interface
    output logic                  enc_trn_start_o,
    output logic [1:0]            enc_trn_type_o,
    output logic                  enc_trn_tvalid_o,
    input  logic                  enc_trn_tready_i,
    output logic                  enc_trn_tlast_o,
    output logic [7:0]            enc_trn_tdata_o,
    // encode_packet tx stream monitor
    input  logic                  tx_tvalid_i,
    input  logic                  tx_tready_i,
    input  logic                  tx_tlast_i,
    // status
    output logic                  busy_o
);

    localparam int        c_IW         = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam logic [3:0] c_GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam tx_state_t c_POST_STATE = (GAP > 0) ? ST_GAP : ST_IDLE;

    tx_state_t           r_state;
    logic [3:0]          r_gap_cnt;
    logic [c_IW-1:0]     r_ptr;
    logic [NUM_EP-1:0]   r_gnt_oh;
    logic                r_hsk_send;
    logic [1:0]          r_hsk_type;
    logic                r_hsk_ack;
    logic                r_tok_send;
    logic [1:0]          r_tok_type;
    logic [15:0]         r_tok_data;
    logic                r_tok_ack;
    logic                r_trn_start;
    logic [1:0]          r_trn_type;
    logic [NUM_EP-1:0]   r_ep_done;

    logic [NUM_EP-1:0]   w_gnt;
    logic [c_IW-1:0]     w_idx;
    logic                w_ep_valid;
    logic [c_IW-1:0]     w_ptr_next;
    logic [1:0]          w_ep_type;
    logic                w_sel_tvalid;
    logic                w_sel_tlast;
    logic [7:0]          w_sel_tdata;
    logic                w_in_data;
    logic                w_tx_last;

    rr_arbiter #(
        .N  (NUM_EP),
        .IW (c_IW)
    ) u_rr (
        .i_req   (ep_req_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_ep_valid)
    );

    assign w_ptr_next = (w_idx == c_IW'(NUM_EP - 1)) ? '0 : w_idx + 1'b1;
    assign w_in_data  = (r_state == ST_DATA);
    assign w_tx_last  = tx_tvalid_i & tx_tready_i & tx_tlast_i;

    // Pick the DATAx type of the endpoint about to be granted
    always_comb begin
        w_ep_type = 2'b00;
        for (int i = 0; i < NUM_EP; i++) begin
            if (w_gnt[i]) begin
                w_ep_type = ep_type_i[2*i +: 2];
            end
        end
    end

    // Stream mux from the granted endpoint towards encode_packet
    always_comb begin
        w_sel_tvalid = 1'b0;
        w_sel_tlast  = 1'b0;
        w_sel_tdata  = 8'h00;
        for (int i = 0; i < NUM_EP; i++) begin
            if (r_gnt_oh[i]) begin
                w_sel_tvalid = ep_tvalid_i[i];
                w_sel_tlast  = ep_tlast_i[i];
                w_sel_tdata  = ep_tdata_i[8*i +: 8];
            end
        end
    end

    // Grant FSM: priority hsk > tok > endpoints, one packet then a gap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= 4'd0;
            r_ptr       <= '0;
            r_gnt_oh    <= '0;
            r_hsk_send  <= 1'b0;
            r_hsk_type  <= 2'b00;
            r_hsk_ack   <= 1'b0;
            r_tok_send  <= 1'b0;
            r_tok_type  <= 2'b00;
            r_tok_data  <= 16'h0000;
            r_tok_ack   <= 1'b0;
            r_trn_start <= 1'b0;
            r_trn_type  <= 2'b00;
            r_ep_done   <= '0;
        end else begin
            r_hsk_ack <= 1'b0;
            r_tok_ack <= 1'b0;
            r_ep_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (hsk_req_i) begin
                        r_hsk_type <= hsk_type_i;
                        r_hsk_send <= 1'b1;
                        r_state    <= ST_HSK;
                    end else if (tok_req_i) begin
                        r_tok_type <= tok_type_i;
                        r_tok_data <= tok_data_i;
                        r_tok_send <= 1'b1;
                        r_state    <= ST_TOK;
                    end else if (w_ep_valid) begin
                        r_gnt_oh    <= w_gnt;
                        r_ptr       <= w_ptr_next;
                        r_trn_type  <= w_ep_type;
                        r_trn_start <= 1'b1;
                        r_state     <= ST_DSTART;
                    end
                end
                ST_HSK: begin
                    if (enc_hsk_done_i) begin
                        r_hsk_send <= 1'b0;
                        r_hsk_ack  <= 1'b1;
                        r_gap_cnt  <= c_GAP_LOAD;
                        r_state    <= c_POST_STATE;
                    end
                end
                ST_TOK: begin
                    if (enc_tok_done_i) begin
                        r_tok_send <= 1'b0;
                        r_tok_ack  <= 1'b1;
                        r_gap_cnt  <= c_GAP_LOAD;
                        r_state    <= c_POST_STATE;
                    end
                end
                ST_DSTART: begin
                    r_trn_start <= 1'b0;
                    r_state     <= ST_DATA;
                end
                ST_DATA: begin
                    // the CRC bytes follow the endpoint's tlast, so only the
                    // encoder's own final beat closes the packet
                    if (w_tx_last) begin
                        r_ep_done <= r_gnt_oh;
                        r_gap_cnt <= c_GAP_LOAD;
                        r_state   <= c_POST_STATE;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hsk_ack_o        = r_hsk_ack;
    assign tok_ack_o        = r_tok_ack;
    assign ep_done_o        = r_ep_done;
    assign enc_hsk_send_o   = r_hsk_send;
    assign enc_hsk_type_o   = r_hsk_type;
    assign enc_tok_send_o   = r_tok_send;
    assign enc_tok_type_o   = r_tok_type;
    assign enc_tok_data_o   = r_tok_data;
    assign enc_trn_start_o  = r_trn_start;
    assign enc_trn_type_o   = r_trn_type;
    assign enc_trn_tvalid_o = w_in_data & w_sel_tvalid;
    assign enc_trn_tlast_o  = w_in_data & w_sel_tlast;
    assign enc_trn_tdata_o  = w_in_data ? w_sel_tdata : 8'h00;
    assign ep_tready_o      = (w_in_data && enc_trn_tready_i) ? r_gnt_oh : '0;
    assign busy_o           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
